// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, fetches start_addr..stop_addr (inclusive, wrapping)
// over a req/ack memory handshake and hands each word to decode over a valid/stall handshake.
module fetch_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [ADDR_W-1:0]  start_addr,
    input  logic [ADDR_W-1:0]  stop_addr,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               stall,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  fetch_cnt
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] last;

    // imem_addr doubles as the PC register, so the address is registered by construction.
    // NOTE: every state/output register uses non-blocking assignment so all of them update
    // from the same pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            last        <= '0;
            imem_req    <= 1'b0;
            imem_addr   <= '0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            fetch_cnt   <= '0;
        end else if (abort && state != IDLE) begin
            // A coincident ack is dropped; fetch_cnt keeps the count reached so far.
            state       <= IDLE;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= REQ;
                        imem_addr <= start_addr;
                        last      <= stop_addr;
                        fetch_cnt <= '0;
                        imem_req  <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                REQ: begin
                    if (imem_ack) begin
                        state       <= HOLD;
                        instr       <= imem_data;
                        instr_pc    <= imem_addr;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        fetch_cnt   <= fetch_cnt + ADDR_W'(1);
                        instr_valid <= 1'b0;
                        if (imem_addr == last) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= REQ;
                            imem_addr <= imem_addr + ADDR_W'(1);
                            imem_req  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: table-driven runs, randomized handshake runs
// scored against an address-sequence model, and hand-written abort/reset/ignore sequences.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  start_addr = '0;
    logic [7:0]  stop_addr = '0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_data;
    logic        stall = 1'b0;
    logic        instr_valid;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic        busy;
    logic        done;
    logic [7:0]  fetch_cnt;

    int checks = 0;
    int passes = 0;

    fetch_sequencer #(.ADDR_W(8), .INSTR_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .start_addr(start_addr), .stop_addr(stop_addr),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .stall(stall), .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .busy(busy), .done(done), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    // Instruction memory contents: a fixed, address-unique pattern.
    function automatic logic [15:0] mem_word(input logic [7:0] a);
        return {a ^ 8'h5A, ~a} + 16'h1357;
    endfunction

    assign imem_data = mem_word(imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        check(name, {imem_req, imem_addr, instr_valid, instr, instr_pc, busy, done, fetch_cnt}, 32'h0);
    endtask

    // Runs one program and scores it against the list of PCs s, s+1, ... e (mod 256).
    task automatic run_fetch(input logic [7:0] s, input logic [7:0] e, input int max_delay,
                             input int stall_pct, input bit noise, output int done_cycle);
        logic [7:0]  exp_q[$];
        logic [7:0]  p;
        logic [7:0]  prev_addr, prev_pc;
        logic [15:0] prev_instr;
        bit          prev_req_wait, prev_stalled;
        int          len, cyc, delay_left;
        len = int'(8'(e - s)) + 1;
        for (int i = 0; i < len; i++) exp_q.push_back(8'(s + 8'(i)));
        start_addr = s; stop_addr = e; start = 1'b1; imem_ack = 1'b0; stall = 1'b0;
        tick();
        start = 1'b0;
        check("start_req", imem_req, 1);
        check("start_addr", imem_addr, s);
        check("start_cnt", fetch_cnt, 0);
        delay_left = $urandom_range(max_delay, 0);
        prev_req_wait = 1'b0; prev_stalled = 1'b0;
        prev_addr = '0; prev_pc = '0; prev_instr = '0;
        done_cycle = -1;
        cyc = 1;
        while (done_cycle < 0 && cyc < 3000) begin
            check("no_overlap", imem_req && instr_valid, 0);
            if (prev_req_wait) check("req_hold", {imem_req, imem_addr}, {1'b1, prev_addr});
            if (prev_stalled) check("stall_hold", {instr_valid, instr_pc, instr}, {1'b1, prev_pc, prev_instr});
            if (done) begin
                done_cycle = cyc;
                check("done_busy", busy, 1);
                check("done_all_consumed", exp_q.size(), 0);
                check("done_cnt", fetch_cnt, 8'(len));
            end else begin
                imem_ack = 1'b0;
                stall = 1'b0;
                if (imem_req) begin
                    if (delay_left == 0) begin
                        imem_ack = 1'b1;
                        delay_left = $urandom_range(max_delay, 0);
                    end else delay_left--;
                end else imem_ack = noise && ($urandom_range(3, 0) == 0);
                if (instr_valid) begin
                    stall = ($urandom_range(99, 0) < stall_pct);
                    if (!stall) begin
                        if (exp_q.size() == 0) check("extra_instr", 1, 0);
                        else begin
                            p = exp_q.pop_front();
                            check("instr_pc", instr_pc, p);
                            check("instr", instr, mem_word(p));
                        end
                    end
                end else stall = noise && ($urandom_range(1, 0) == 1);
                if (noise) begin
                    start = ($urandom_range(7, 0) == 0);
                    start_addr = 8'($urandom);
                    stop_addr = 8'($urandom);
                end
                prev_req_wait = imem_req && !imem_ack;
                prev_addr = imem_addr;
                prev_stalled = instr_valid && stall;
                prev_pc = instr_pc;
                prev_instr = instr;
                tick();
                cyc++;
            end
        end
        if (done_cycle < 0) check("done_timeout", 0, 1);
        start = 1'b0; imem_ack = 1'b0; stall = 1'b0;
        tick();
        check("post_done", {busy, done, fetch_cnt}, {2'b00, 8'(len)});
    endtask

    typedef struct {
        logic [7:0] s;
        logic [7:0] e;
        int         exp_len;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs[4];
    int   dc;
    logic [7:0] s_r, saved_addr;

    initial begin
        vecs[0] = '{8'h10, 8'h13, 4,   8'd4};
        vecs[1] = '{8'hFE, 8'h01, 4,   8'd4};
        vecs[2] = '{8'h55, 8'h55, 1,   8'd1};
        vecs[3] = '{8'h00, 8'hFF, 256, 8'd0};

        tick(); tick();
        check_all_zero("reset_state");
        reset = 1'b1;
        tick();
        check_all_zero("idle_after_reset");

        // Zero-wait memory, no stall: exact 2L+1 latency to done.
        foreach (vecs[i]) begin
            run_fetch(vecs[i].s, vecs[i].e, 0, 0, 1'b0, dc);
            check("run_cycles", dc, 2 * vecs[i].exp_len + 1);
            check("end_cnt", fetch_cnt, vecs[i].exp_cnt);
        end

        // Ack while idle must change nothing.
        saved_addr = imem_addr;
        imem_ack = 1'b1;
        tick(); tick(); tick();
        imem_ack = 1'b0;
        check("idle_ack", {imem_req, instr_valid, busy, done, imem_addr, fetch_cnt},
              {4'b0000, saved_addr, 8'd0});

        // Randomized handshake stress with start/ack/stall noise.
        for (int r = 0; r < 12; r++) begin
            s_r = 8'($urandom);
            run_fetch(s_r, 8'(s_r + 8'($urandom_range(40, 0))), 5, 40, 1'b1, dc);
        end

        // Abort in REQ coinciding with ack, after two consumed instructions.
        start_addr = 8'h20; stop_addr = 8'h30; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            imem_ack = 1'b1; tick();
            imem_ack = 1'b0; stall = 1'b0; tick();
        end
        check("pre_abort_req", {imem_req, imem_addr, fetch_cnt}, {1'b1, 8'h22, 8'd2});
        imem_ack = 1'b1; abort = 1'b1;
        tick();
        imem_ack = 1'b0; abort = 1'b0;
        check("abort_req", {imem_req, instr_valid, busy, done, fetch_cnt}, {4'b0000, 8'd2});
        tick();
        check("abort_req_after", {imem_req, instr_valid, busy, done, fetch_cnt}, {4'b0000, 8'd2});

        // Abort in HOLD while stalled; start pulsed mid-run must be ignored.
        start_addr = 8'h40; stop_addr = 8'h41; start = 1'b1;
        tick();
        start_addr = 8'h90; stop_addr = 8'h90;
        tick();
        start = 1'b0;
        check("start_ignored", {imem_req, imem_addr, fetch_cnt}, {1'b1, 8'h40, 8'd0});
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0; stall = 1'b1;
        tick();
        check("hold_stalled", {instr_valid, instr_pc, instr}, {1'b1, 8'h40, mem_word(8'h40)});
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_hold", {imem_req, instr_valid, busy, done, fetch_cnt}, {4'b0000, 8'd0});
        stall = 1'b0;

        // Reset held for two edges mid-HOLD, then a normal run.
        start_addr = 8'h70; stop_addr = 8'h75; start = 1'b1;
        tick();
        start = 1'b0; imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0; stall = 1'b1;
        tick();
        check("pre_reset_hold", instr_valid, 1);
        reset = 1'b0;
        tick();
        check_all_zero("reset_mid_hold_1");
        tick();
        check_all_zero("reset_mid_hold_2");
        reset = 1'b1; stall = 1'b0;
        tick();
        run_fetch(8'h10, 8'h13, 0, 0, 1'b0, dc);
        check("post_reset_cycles", dc, 9);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Sequences instruction fetch for the processor: it owns the program-counter register, issues one instruction-memory request per address over a req/ack handshake, and presents each fetched word to the decode stage under a valid/stall handshake. It runs a linear program from `start_addr` to `stop_addr` inclusive. The ISA has no control-transfer instructions, so the PC only increments or wraps. It sits between the instruction memory and the decode/execute datapath.

## Interface
- `ADDR_W`, 8, PC / instruction-memory address width
- `INSTR_W`, 16, instruction word width
- `clk`  in  1  clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-low; clock clk
- `start`  in  1  begin a run; honoured only in IDLE
- `abort`  in  1  terminate the run; honoured in any non-IDLE state
- `start_addr`  in  ADDR_W  first PC of the run, sampled on the accepted `start` edge
- `stop_addr`  in  ADDR_W  last PC of the run, sampled on the accepted `start` edge
- `imem_req`  out  1  instruction-memory read request
- `imem_addr`  out  ADDR_W  current PC
- `imem_ack`  in  1  memory has `imem_data` valid this cycle
- `imem_data`  in  INSTR_W  instruction word
- `stall`  in  1  decode cannot accept `instr` this cycle
- `instr_valid`  out  1  `instr` / `instr_pc` hold an unconsumed instruction
- `instr`  out  INSTR_W  fetched instruction
- `instr_pc`  out  ADDR_W  address of `instr`
- `busy`  out  1  a run is in progress (state != IDLE)
- `done`  out  1  one-cycle pulse at the normal end of a run
- `fetch_cnt`  out  ADDR_W  instructions consumed in the current or last run

## Operation
- All outputs are registered. Every output resets to 0 when `reset`=0 at a clock edge.
- State machine:
  - IDLE → REQ on `start`=1. Load pc←`start_addr` and last←`stop_addr`; clear `fetch_cnt`.
  - REQ: `imem_req`=1, `imem_addr`=pc. Request and address stay stable until ack. On an edge with `imem_ack`=1: `instr`←`imem_data`, `instr_pc`←pc, `instr_valid`←1, go to HOLD.
  - HOLD: `instr_valid`=1; `instr` and `instr_pc` stay stable while `stall`=1. On an edge with `stall`=0 the instruction is consumed:
    - `fetch_cnt`+1 and `instr_valid`←0.
    - If pc==last, go to DONE.
    - Otherwise pc←pc+1 (mod 2^ADDR_W) and go to REQ.
  - DONE: `done`=1 for exactly one cycle, then IDLE. `busy` stays 1 during DONE.
- Priority at each edge: reset > abort > normal transitions.
- `abort`=1 in REQ, HOLD or DONE:
  - Next state is IDLE.
  - `imem_req`←0 and `instr_valid`←0.
  - No `done` pulse; `fetch_cnt` holds its value.
  - An ack coinciding with abort is discarded.
- `start` is ignored outside IDLE.
- `imem_ack` is ignored unless `imem_req`=1.
- Wrap-around: if `start_addr` > `stop_addr`, the PC goes through 2^ADDR_W−1 → 0 and continues to `stop_addr`.
- `start_addr`==`stop_addr`: exactly one instruction is fetched.
- `fetch_cnt` wraps mod 2^ADDR_W. A full 256-instruction run shows 0.
- `reset` low mid-run returns to IDLE immediately with all outputs 0; memory must tolerate a dropped request.

## Timing
- `start` accepted at edge N → `imem_req`=1, `imem_addr`=`start_addr` from cycle N+1.
- Ack sampled at edge M → `instr_valid`=1 from cycle M+1, and `imem_req`=0 in that same cycle.
- Consumption at edge K → next `imem_req` from cycle K+1. If it was the last instruction, `done`=1 in cycle K+1 and `busy`=0 from cycle K+2.
- Zero-wait memory with no stall gives 2 cycles per instruction. An L-instruction run takes 2L+1 cycles from start-edge to `done`.
- No request ever overlaps a held instruction (`imem_req` and `instr_valid` are never both 1).

## Test plan
- Reset: hold `reset`=0 for 2 edges mid-HOLD → all outputs 0, state IDLE; next `start` proceeds normally.
- Basic run: start 0x10, stop 0x13, ack every request in the same cycle, `stall`=0 → `instr_pc` sequence 0x10–0x13; `done` pulse at cycle 9 after the start edge; `fetch_cnt`=4.
- Handshake stress: random ack delays of 0–5 and random stall → `imem_addr` stable while req is high, `instr` stable while stalled, no instruction lost or duplicated; compare against a memory model.
- Wrap: start 0xFE, stop 0x01 → PCs 0xFE, 0xFF, 0x00, 0x01; `fetch_cnt`=4. Also start==stop==0x55 → a single fetch, then `done`.
- Abort: abort in REQ coincident with ack, and separately abort in HOLD → IDLE next cycle, `instr_valid`=0, no `done`, `fetch_cnt` holds.
- Ignored inputs: `start` pulsed mid-run and `imem_ack` high while idle → no effect on PC, outputs, or `fetch_cnt`.
